// File: rtl/ahb_reg_slice_pkg.sv
// Shared definitions for the AHB register slice: HTRANS/HRESP encodings,
// the SINGLE burst code and the slice state type.
package ahb_reg_slice_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_ERR1,
    ST_ERR2
  } slice_state_e;

endpackage

// File: rtl/ahb_slice_errcnt.sv
// Saturating 16-bit error event counter for the AHB register slice.
// Only present when AHB_SLICE_ERRCNT_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : one-cycle pulse per error event
//   cnt        : current count, sticks at 16'hFFFF
`ifdef AHB_SLICE_ERRCNT_EN
module ahb_slice_errcnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule
`endif

// File: rtl/ahb_reg_slice.sv
// AHB register slice: registers one upstream transfer at a time and replays
// it downstream as a NONSEQ SINGLE transfer (bursts are split into singles).
// Optional feature macro: AHB_SLICE_ERRCNT_EN adds the err_cnt output.
// Ports:
//   hclk, hresetn       : bus clock, asynchronous active-low reset
//   s_* (inputs)        : upstream slave-side address/control/write data, bus HREADY
//   s_hreadyout/hresp/hrdata : upstream response
//   m_* (outputs)       : downstream master-side address/control/write data
//   m_hready/hresp/hrdata    : downstream response
//   err_cnt             : saturating count of downstream ERROR responses (macro only)
module ahb_reg_slice
  import ahb_reg_slice_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              s_hsel,
  input  logic [ADDR_W-1:0] s_haddr,
  input  logic [1:0]        s_htrans,
  input  logic              s_hwrite,
  input  logic [2:0]        s_hsize,
  input  logic [2:0]        s_hburst,
  input  logic [DATA_W-1:0] s_hwdata,
  input  logic              s_hready,
  output logic              s_hreadyout,
  output logic              s_hresp,
  output logic [DATA_W-1:0] s_hrdata,
  output logic [ADDR_W-1:0] m_haddr,
  output logic [1:0]        m_htrans,
  output logic              m_hwrite,
  output logic [2:0]        m_hsize,
  output logic [2:0]        m_hburst,
  output logic [DATA_W-1:0] m_hwdata,
  input  logic              m_hready,
  input  logic              m_hresp,
  input  logic [DATA_W-1:0] m_hrdata
`ifdef AHB_SLICE_ERRCNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  slice_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              write_q, write_d;
  logic [2:0]        size_q,  size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              accept;

  // Burst type is deliberately dropped: every beat goes out as SINGLE.
  logic unused_hburst;
  assign unused_hburst = ^s_hburst;

  assign accept = s_hsel && s_hready &&
                  ((s_htrans == HTRANS_NONSEQ) || (s_htrans == HTRANS_SEQ)) &&
                  ((state_q == ST_IDLE) || (state_q == ST_RESP));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          state_d = ST_ADDR;
          addr_d  = s_haddr;
          write_d = s_hwrite;
          size_d  = s_hsize;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        // Upstream data phase overlaps this state; last sample wins.
        wdata_d = s_hwdata;
        if (m_hready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (m_hresp) begin
          state_d = ST_ERR1;
        end else if (m_hready) begin
          rdata_d = m_hrdata;
          state_d = ST_RESP;
        end
      end
      ST_ERR1: if (m_hready) state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    m_htrans    = HTRANS_IDLE;
    s_hreadyout = 1'b1;
    s_hresp     = HRESP_OKAY;
    case (state_q)
      ST_ADDR: begin
        m_htrans    = HTRANS_NONSEQ;
        s_hreadyout = 1'b0;
      end
      ST_DATA: s_hreadyout = 1'b0;
      ST_ERR1: begin
        s_hreadyout = 1'b0;
        s_hresp     = HRESP_ERROR;
      end
      ST_ERR2: s_hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  assign m_haddr  = addr_q;
  assign m_hwrite = write_q;
  assign m_hsize  = size_q;
  assign m_hburst = HBURST_SINGLE;
  assign m_hwdata = wdata_q;
  assign s_hrdata = rdata_q;

`ifdef AHB_SLICE_ERRCNT_EN
  logic err_inc;
  assign err_inc = (state_q == ST_DATA) && m_hresp;

  ahb_slice_errcnt u_errcnt (
    .clk   (hclk),
    .rst_n (hresetn),
    .inc   (err_inc),
    .cnt   (err_cnt)
  );
`endif

endmodule

// File: tb/tb_ahb_reg_slice.sv
// Self-checking bench for ahb_reg_slice. The bench plays both the upstream
// master and the downstream slave; each transaction's downstream wait/error
// profile is chosen up front, so the expected upstream/downstream outputs
// for every cycle follow directly from the bridge's latency rules.
module tb_ahb_reg_slice;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          s_hsel;
  logic [AW-1:0] s_haddr;
  logic [1:0]    s_htrans;
  logic          s_hwrite;
  logic [2:0]    s_hsize;
  logic [2:0]    s_hburst;
  logic [DW-1:0] s_hwdata;
  logic          s_hready;
  logic          s_hreadyout;
  logic          s_hresp;
  logic [DW-1:0] s_hrdata;
  logic [AW-1:0] m_haddr;
  logic [1:0]    m_htrans;
  logic          m_hwrite;
  logic [2:0]    m_hsize;
  logic [2:0]    m_hburst;
  logic [DW-1:0] m_hwdata;
  logic          m_hready;
  logic          m_hresp;
  logic [DW-1:0] m_hrdata;
`ifdef AHB_SLICE_ERRCNT_EN
  logic [15:0]   err_cnt;
`endif

  ahb_reg_slice #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .s_hsel      (s_hsel),
    .s_haddr     (s_haddr),
    .s_htrans    (s_htrans),
    .s_hwrite    (s_hwrite),
    .s_hsize     (s_hsize),
    .s_hburst    (s_hburst),
    .s_hwdata    (s_hwdata),
    .s_hready    (s_hready),
    .s_hreadyout (s_hreadyout),
    .s_hresp     (s_hresp),
    .s_hrdata    (s_hrdata),
    .m_haddr     (m_haddr),
    .m_htrans    (m_htrans),
    .m_hwrite    (m_hwrite),
    .m_hsize     (m_hsize),
    .m_hburst    (m_hburst),
    .m_hwdata    (m_hwdata),
    .m_hready    (m_hready),
    .m_hresp     (m_hresp),
    .m_hrdata    (m_hrdata)
`ifdef AHB_SLICE_ERRCNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [2:0]    size;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int unsigned   aw;   // downstream address-phase wait cycles
    int unsigned   dw;   // downstream data-phase wait cycles
    logic          err;  // downstream answers ERROR
    int unsigned   ew;   // extra ERR1 cycles before m_hready
    logic          seq;  // presented as SEQ (burst continuation)
  } txn_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned acc_cyc  = 0;
  int unsigned prev_acc = 0;
  int          hresp_seen = 0;

  // Model / expectation state
  logic          exp_valid = 1'b0;
  logic          exp_rdy, exp_resp, exp_rst, exp_addr_chk, exp_wd_chk;
  logic [1:0]    exp_htrans;
  logic [AW-1:0] exp_addr;
  logic          exp_write;
  logic [2:0]    exp_size;
  logic [DW-1:0] exp_wdata;
  logic [DW-1:0] model_rdata;
  logic [15:0]   model_errs;

  always @(posedge hclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge hclk) begin
    if (exp_valid) begin
      check("s_hreadyout", s_hreadyout, exp_rdy);
      check("s_hresp", s_hresp, exp_resp);
      check("m_htrans", m_htrans, exp_htrans);
      check("m_hburst", m_hburst, 3'b000);
      check("s_hrdata", s_hrdata, model_rdata);
      if (exp_addr_chk) begin
        check("m_haddr", m_haddr, exp_addr);
        check("m_hwrite", m_hwrite, exp_write);
        check("m_hsize", m_hsize, exp_size);
      end
      if (exp_wd_chk) check("m_hwdata", m_hwdata, exp_wdata);
      if (exp_rst) begin
        check("rst_m_haddr", m_haddr, '0);
        check("rst_m_hwdata", m_hwdata, '0);
        check("rst_m_hwrite", m_hwrite, 1'b0);
        check("rst_m_hsize", m_hsize, 3'b000);
      end
`ifdef AHB_SLICE_ERRCNT_EN
      check("err_cnt", err_cnt, model_errs);
`endif
      if (s_hresp) hresp_seen++;
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_exp(input logic rdy, input logic resp, input logic [1:0] ht);
    exp_rdy      = rdy;
    exp_resp     = resp;
    exp_htrans   = ht;
    exp_addr_chk = 1'b0;
    exp_wd_chk   = 1'b0;
    exp_rst      = 1'b0;
    exp_valid    = 1'b1;
  endtask

  // Upstream activity that must never be accepted.
  task automatic up_noaccept();
    s_haddr  = $urandom;
    s_hwrite = 1'($urandom);
    s_hsize  = 3'($urandom_range(0, 2));
    s_hburst = 3'($urandom);
    s_hwdata = $urandom;
    case ($urandom_range(0, 2))
      0: begin s_hsel = 1'b0; s_htrans = 2'($urandom); s_hready = 1'b1; end
      1: begin s_hsel = 1'b1; s_htrans = 2'($urandom_range(0, 1)); s_hready = 1'b1; end
      default: begin s_hsel = 1'($urandom); s_htrans = 2'($urandom); s_hready = 1'b0; end
    endcase
  endtask

  task automatic dn_idle();
    m_hready = 1'b1;
    m_hresp  = 1'b0;
    m_hrdata = $urandom;
  endtask

  task automatic idle_cycle();
    up_noaccept();
    dn_idle();
    set_exp(1'b1, 1'b0, 2'b00);
    tick();
  endtask

  // Runs one transfer from its accept cycle; returns at the start of the
  // RESP cycle (success) or of the IDLE cycle following ERR2 (error).
  task automatic run_txn(input txn_t t);
    s_hsel   = 1'b1;
    s_haddr  = t.addr;
    s_htrans = t.seq ? 2'b11 : 2'b10;
    s_hwrite = t.wr;
    s_hsize  = t.size;
    s_hburst = 3'($urandom);
    s_hwdata = $urandom;
    s_hready = 1'b1;
    dn_idle();
    set_exp(1'b1, 1'b0, 2'b00);
    prev_acc = acc_cyc;
    acc_cyc  = cyc;
    tick();
    for (int unsigned i = 0; i <= t.aw; i++) begin
      up_noaccept();
      s_hwdata = t.wdata;
      m_hready = (i == t.aw);
      m_hresp  = 1'b0;
      m_hrdata = $urandom;
      set_exp(1'b0, 1'b0, 2'b10);
      exp_addr_chk = 1'b1;
      exp_addr     = t.addr;
      exp_write    = t.wr;
      exp_size     = t.size;
      tick();
    end
    for (int unsigned i = 0; i <= t.dw; i++) begin
      up_noaccept();
      m_hready = 1'b0;
      m_hresp  = 1'b0;
      m_hrdata = $urandom;
      if (i == t.dw) begin
        if (t.err) m_hresp = 1'b1;
        else begin m_hready = 1'b1; m_hrdata = t.rdata; end
      end
      set_exp(1'b0, 1'b0, 2'b00);
      exp_wd_chk = 1'b1;
      exp_wdata  = t.wdata;
      tick();
    end
    if (t.err) begin
      if (model_errs != 16'hFFFF) model_errs = model_errs + 16'd1;
      for (int unsigned i = 0; i <= t.ew; i++) begin
        up_noaccept();
        m_hresp  = 1'b1;
        m_hready = (i == t.ew);
        m_hrdata = $urandom;
        set_exp(1'b0, 1'b1, 2'b00);
        tick();
      end
      // A transfer offered during ERR2 is cancelled by the master and must be ignored.
      s_hsel   = 1'b1;
      s_htrans = 2'b10;
      s_hready = 1'b1;
      s_haddr  = $urandom;
      dn_idle();
      set_exp(1'b1, 1'b1, 2'b00);
      tick();
    end else begin
      model_rdata = t.rdata;
    end
  endtask

  function automatic txn_t mk(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                              input logic [DW-1:0] rd, input int unsigned dw, input logic err,
                              input logic seq);
    txn_t t;
    t.addr = a; t.wr = wr; t.size = 3'd2; t.wdata = wd; t.rdata = rd;
    t.aw = 0; t.dw = dw; t.err = err; t.ew = 0; t.seq = seq;
    return t;
  endfunction

  initial begin
    txn_t t;
    hresetn     = 1'b0;
    model_rdata = '0;
    model_errs  = '0;
    up_noaccept();
    dn_idle();
    set_exp(1'b1, 1'b0, 2'b00);
    exp_rst = 1'b1;
    tick();
    tick();
    hresetn = 1'b1;
    idle_cycle();

    // Single write, zero-wait downstream: RESP three cycles after accept.
    run_txn(mk(32'h1000, 1'b1, 32'hDEADBEEF, 32'h0, 0, 1'b0, 1'b0));
    check("write_latency", cyc - acc_cyc, 3);
    idle_cycle();

    // Read with two downstream wait states.
    run_txn(mk(32'h2004, 1'b0, 32'h0, 32'h12345678, 2, 1'b0, 1'b0));
    check("read_latency", cyc - acc_cyc, 5);
    check("read_data", s_hrdata, 32'h12345678);
    idle_cycle();

    // Downstream ERROR: two cycles of s_hresp.
    hresp_seen = 0;
    run_txn(mk(32'h3000, 1'b1, 32'hCAFEF00D, 32'h0, 0, 1'b1, 1'b0));
    check("err_resp_cycles", hresp_seen, 2);
`ifdef AHB_SLICE_ERRCNT_EN
    check("err_cnt_one", err_cnt, 16'd1);
`endif
    idle_cycle();

    // INCR4 burst split into back-to-back singles.
    for (int i = 0; i < 4; i++) begin
      run_txn(mk(32'h4000 + 32'(4 * i), 1'b1, $urandom, $urandom, 0, 1'b0, i != 0));
      if (i != 0) check("burst_gap", acc_cyc - prev_acc, 3);
    end
    idle_cycle();

    // Selected IDLE/BUSY transfers: no downstream activity, OKAY zero-wait.
    for (int i = 0; i < 4; i++) begin
      s_hsel = 1'b1; s_htrans = 2'(i % 2); s_hready = 1'b1; s_haddr = $urandom;
      dn_idle();
      set_exp(1'b1, 1'b0, 2'b00);
      tick();
    end

    // Reset asserted during the downstream data phase.
    t = mk(32'h5000, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    s_hsel = 1'b1; s_haddr = t.addr; s_htrans = 2'b10; s_hwrite = 1'b0; s_hsize = 3'd2;
    s_hready = 1'b1;
    dn_idle();
    set_exp(1'b1, 1'b0, 2'b00);
    tick();
    up_noaccept();
    dn_idle();
    set_exp(1'b0, 1'b0, 2'b10);
    exp_addr_chk = 1'b1; exp_addr = t.addr; exp_write = 1'b0; exp_size = 3'd2;
    tick();
    up_noaccept();
    m_hready = 1'b0;
    #1;
    hresetn     = 1'b0;
    model_rdata = '0;
    model_errs  = '0;
    set_exp(1'b1, 1'b0, 2'b00);
    exp_rst = 1'b1;
    tick();
    hresetn = 1'b1;
    up_noaccept();
    dn_idle();
    set_exp(1'b1, 1'b0, 2'b00);
    exp_rst = 1'b1;
    tick();
    run_txn(mk(32'h6000, 1'b0, 32'h0, 32'hA5A5_0F0F, 1, 1'b0, 1'b0));
    check("post_reset_read", s_hrdata, 32'hA5A5_0F0F);
    idle_cycle();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      t.addr  = $urandom;
      t.wr    = 1'($urandom);
      t.size  = 3'($urandom_range(0, 2));
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.aw    = ($urandom_range(0, 3) == 0) ? 1 : 0;
      t.dw    = $urandom_range(0, 3);
      t.err   = ($urandom_range(0, 7) == 0);
      t.ew    = $urandom_range(0, 1);
      t.seq   = 1'($urandom);
      run_txn(t);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) idle_cycle();
    end
    idle_cycle();

    exp_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
